// File: rtl/friscv_cache_blocks_pkg.sv
// -----------------------------------------------------------------------------
// friscv_cache_blocks_pkg
//
// Purpose:
//   Shared definitions for the cache storage blocks. Provides the helper
//   functions that split a byte address into offset/index/tag widths and the
//   enum describing what kind of write (if any) landed on a line.
//
// Contents:
//   wr_kind_t     : WR_NONE / WR_FLUSH / WR_REFILL
//   offset_width  : byte-offset bits inside one line
//   index_width   : line index bits
//   tag_width     : remaining upper address bits stored as the tag
// -----------------------------------------------------------------------------
package friscv_cache_blocks_pkg;

    typedef enum logic [1:0] {
        WR_NONE   = 2'd0,
        WR_FLUSH  = 2'd1,
        WR_REFILL = 2'd2
    } wr_kind_t;

    function automatic int offset_width(input int block_w);
        return $clog2(block_w / 8);
    endfunction

    function automatic int index_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int tag_width(input int addr_w, input int depth, input int block_w);
        return addr_w - index_width(depth) - offset_width(block_w);
    endfunction

endpackage

// File: rtl/friscv_cache_ram.sv
// -----------------------------------------------------------------------------
// friscv_cache_ram
//
// Purpose:
//   Simple dual-port RAM: one synchronous write port and one synchronous read
//   port, no reset, so it maps onto block RAM. Read-during-write to the same
//   address returns the old content; the caller resolves that case itself.
//
// Ports:
//   aclk   in  clock
//   wren   in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   rden   in  read enable, rdata updates one cycle later
//   raddr  in  read address
//   rdata  out registered read data
// -----------------------------------------------------------------------------
module friscv_cache_ram #(
    parameter int WIDTH  = 128,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              wren,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rden,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (wren) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (rden) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/friscv_cache_blocks.sv
// -----------------------------------------------------------------------------
// friscv_cache_blocks
//
// Purpose:
//   Cache line storage: one {valid, tag, data} line per index. Accepts flush
//   erase writes (priority) and refill writes, and serves 1-cycle-latency
//   lookups with hit/miss detection plus saturating hit/miss counters.
//
// Ports:
//   aclk, aresetn (async, active-low), srst (sync, active-high)
//   flush_wren/flush_waddr/flush_wdata : erase a line (clears valid)
//   rfl_wren/rfl_ready/rfl_waddr/rfl_wdata : install a line (sets valid)
//   rd_en/rd_addr                       : lookup request
//   rd_valid/rd_hit/rd_data             : lookup result, one cycle later
//   hit_cnt/miss_cnt                    : saturating lookup statistics
// -----------------------------------------------------------------------------
module friscv_cache_blocks
    import friscv_cache_blocks_pkg::*;
#(
    parameter           NAME          = "Cache-Blocks",
    parameter int       CACHE_BLOCK_W = 128,
    parameter int       CACHE_DEPTH   = 128,
    parameter int       AXI_ADDR_W    = 12
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     srst,
    input  logic                     flush_wren,
    input  logic [AXI_ADDR_W-1:0]    flush_waddr,
    input  logic [CACHE_BLOCK_W-1:0] flush_wdata,
    input  logic                     rfl_wren,
    output logic                     rfl_ready,
    input  logic [AXI_ADDR_W-1:0]    rfl_waddr,
    input  logic [CACHE_BLOCK_W-1:0] rfl_wdata,
    input  logic                     rd_en,
    input  logic [AXI_ADDR_W-1:0]    rd_addr,
    output logic                     rd_valid,
    output logic                     rd_hit,
    output logic [CACHE_BLOCK_W-1:0] rd_data,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt
);

    localparam int OFFSET_W = offset_width(CACHE_BLOCK_W);
    localparam int INDEX_W  = index_width(CACHE_DEPTH);
    localparam int TAG_W    = tag_width(AXI_ADDR_W, CACHE_DEPTH, CACHE_BLOCK_W);

    // Index and tag of each port; byte offsets never matter for whole lines.
    logic [INDEX_W-1:0] flush_idx, rfl_idx, rd_idx;
    logic [TAG_W-1:0]   flush_tag, rfl_tag, rd_tag;

    assign flush_idx = flush_waddr[OFFSET_W +: INDEX_W];
    assign flush_tag = flush_waddr[AXI_ADDR_W-1 -: TAG_W];
    assign rfl_idx   = rfl_waddr[OFFSET_W +: INDEX_W];
    assign rfl_tag   = rfl_waddr[AXI_ADDR_W-1 -: TAG_W];
    assign rd_idx    = rd_addr[OFFSET_W +: INDEX_W];
    assign rd_tag    = rd_addr[AXI_ADDR_W-1 -: TAG_W];

    logic unused_bits;
    assign unused_bits = &{1'b0, flush_waddr[OFFSET_W-1:0], rfl_waddr[OFFSET_W-1:0],
                           rd_addr[OFFSET_W-1:0], NAME[7:0]};

    // Single write port: the flusher always wins, a refill waits for a free slot.
    wr_kind_t                 wr_kind;
    logic                     wr_en;
    logic [INDEX_W-1:0]       wr_idx;
    logic [TAG_W-1:0]         wr_tag;
    logic [CACHE_BLOCK_W-1:0] wr_data;

    assign rfl_ready = !flush_wren;

    always_comb begin
        wr_kind = WR_NONE;
        wr_idx  = rfl_idx;
        wr_tag  = rfl_tag;
        wr_data = rfl_wdata;
        if (flush_wren) begin
            wr_kind = WR_FLUSH;
            wr_idx  = flush_idx;
            wr_tag  = flush_tag;
            wr_data = flush_wdata;
        end else if (rfl_wren) begin
            wr_kind = WR_REFILL;
        end
    end

    assign wr_en = (wr_kind != WR_NONE);

    logic [CACHE_BLOCK_W-1:0] ram_data;
    logic [TAG_W-1:0]         ram_tag;

    friscv_cache_ram #(.WIDTH(CACHE_BLOCK_W), .DEPTH(CACHE_DEPTH), .ADDR_W(INDEX_W)) data_ram (
        .aclk  (aclk),
        .wren  (wr_en),
        .waddr (wr_idx),
        .wdata (wr_data),
        .rden  (rd_en),
        .raddr (rd_idx),
        .rdata (ram_data)
    );

    friscv_cache_ram #(.WIDTH(TAG_W), .DEPTH(CACHE_DEPTH), .ADDR_W(INDEX_W)) tag_ram (
        .aclk  (aclk),
        .wren  (wr_en),
        .waddr (wr_idx),
        .wdata (wr_tag),
        .rden  (rd_en),
        .raddr (rd_idx),
        .rdata (ram_tag)
    );

    // Valid bits live in flops so that both resets invalidate every line at
    // once; srst beats any write issued in the same cycle.
    logic [CACHE_DEPTH-1:0] valid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid <= '0;
        end else if (srst) begin
            valid <= '0;
        end else if (wr_kind == WR_FLUSH) begin
            valid[wr_idx] <= 1'b0;
        end else if (wr_kind == WR_REFILL) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Lookup stage: the RAMs read old content on a same-index write, so the
    // write is captured here and overrides the RAM output one cycle later.
    logic                     rd_valid_q;
    logic                     valid_q;
    logic [TAG_W-1:0]         tag_q;
    wr_kind_t                 byp_kind_q;
    logic [TAG_W-1:0]         byp_tag_q;
    logic [CACHE_BLOCK_W-1:0] byp_data_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_valid_q <= 1'b0;
            valid_q    <= 1'b0;
            tag_q      <= '0;
            byp_kind_q <= WR_NONE;
            byp_tag_q  <= '0;
            byp_data_q <= '0;
        end else if (srst) begin
            rd_valid_q <= 1'b0;
            valid_q    <= 1'b0;
            byp_kind_q <= WR_NONE;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                valid_q    <= valid[rd_idx];
                tag_q      <= rd_tag;
                byp_kind_q <= (wr_en && wr_idx == rd_idx) ? wr_kind : WR_NONE;
                byp_tag_q  <= wr_tag;
                byp_data_q <= wr_data;
            end
        end
    end

    // Hit resolution, preferring the captured same-cycle write over the RAM.
    logic                     line_hit;
    logic [CACHE_BLOCK_W-1:0] line_data;

    always_comb begin
        line_hit  = 1'b0;
        line_data = ram_data;
        case (byp_kind_q)
            WR_FLUSH: begin
                line_hit = 1'b0;
            end
            WR_REFILL: begin
                line_hit  = (byp_tag_q == tag_q);
                line_data = byp_data_q;
            end
            default: begin
                line_hit = valid_q && (ram_tag == tag_q);
            end
        endcase
    end

    assign rd_valid = rd_valid_q;
    assign rd_hit   = rd_valid_q && line_hit;
    assign rd_data  = rd_hit ? line_data : '0;

    // Saturating statistics, one count per delivered lookup result.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (srst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rd_valid_q) begin
            if (rd_hit && hit_cnt != 32'hFFFF_FFFF) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else if (!rd_hit && miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_friscv_cache_blocks.sv
// -----------------------------------------------------------------------------
// tb_friscv_cache_blocks
//
// Purpose:
//   Self-checking bench for friscv_cache_blocks. A behavioural line table
//   (valid/tag/data arrays indexed by address arithmetic) predicts every
//   lookup result and counter value; directed scenarios are followed by a
//   randomized traffic phase.
// -----------------------------------------------------------------------------
module tb_friscv_cache_blocks;

    localparam int BLOCK_W = 128;
    localparam int DEPTH   = 128;
    localparam int ADDR_W  = 12;
    localparam int BYTES   = BLOCK_W / 8;

    logic               aclk = 1'b0;
    logic               aresetn;
    logic               srst;
    logic               flush_wren;
    logic [ADDR_W-1:0]  flush_waddr;
    logic [BLOCK_W-1:0] flush_wdata;
    logic               rfl_wren;
    logic               rfl_ready;
    logic [ADDR_W-1:0]  rfl_waddr;
    logic [BLOCK_W-1:0] rfl_wdata;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_valid;
    logic               rd_hit;
    logic [BLOCK_W-1:0] rd_data;
    logic [31:0]        hit_cnt;
    logic [31:0]        miss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    friscv_cache_blocks #(
        .NAME          ("Cache-Blocks"),
        .CACHE_BLOCK_W (BLOCK_W),
        .CACHE_DEPTH   (DEPTH),
        .AXI_ADDR_W    (ADDR_W)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .srst        (srst),
        .flush_wren  (flush_wren),
        .flush_waddr (flush_waddr),
        .flush_wdata (flush_wdata),
        .rfl_wren    (rfl_wren),
        .rfl_ready   (rfl_ready),
        .rfl_waddr   (rfl_waddr),
        .rfl_wdata   (rfl_wdata),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_hit      (rd_hit),
        .rd_data     (rd_data),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    // Reference cache: a plain table of lines plus the currently expected
    // lookup result and counter totals.
    bit                 m_valid [DEPTH];
    int unsigned        m_tag   [DEPTH];
    logic [BLOCK_W-1:0] m_data  [DEPTH];
    bit                 exp_rv;
    bit                 exp_hit;
    logic [BLOCK_W-1:0] exp_data;
    longint unsigned    exp_hits;
    longint unsigned    exp_misses;

    function automatic int unsigned line_of(input logic [ADDR_W-1:0] a);
        return (int'(a) / BYTES) % DEPTH;
    endfunction

    function automatic int unsigned tag_of(input logic [ADDR_W-1:0] a);
        return int'(a) / (BYTES * DEPTH);
    endfunction

    function automatic logic [31:0] sat32(input longint unsigned v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [BLOCK_W-1:0] obs,
                               input logic [BLOCK_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational ready, advance
    // the reference model across the edge, then check the registered outputs.
    task automatic applyStimulus(input logic s,
                                 input logic f, input logic [ADDR_W-1:0] fa,
                                 input logic [BLOCK_W-1:0] fd,
                                 input logic r, input logic [ADDR_W-1:0] ra,
                                 input logic [BLOCK_W-1:0] rdt,
                                 input logic rd, input logic [ADDR_W-1:0] rda);
        srst        = s;
        flush_wren  = f;
        flush_waddr = fa;
        flush_wdata = fd;
        rfl_wren    = r;
        rfl_waddr   = ra;
        rfl_wdata   = rdt;
        rd_en       = rd;
        rd_addr     = rda;
        #1;
        checkOutput("rfl_ready", {127'd0, rfl_ready}, {127'd0, !f});
        @(posedge aclk);
        #1;
        if (s) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            exp_rv     = 1'b0;
            exp_hit    = 1'b0;
            exp_data   = '0;
            exp_hits   = 0;
            exp_misses = 0;
        end else begin
            if (exp_rv) begin
                if (exp_hit) exp_hits++;
                else         exp_misses++;
            end
            if (f) begin
                m_valid[line_of(fa)] = 1'b0;
            end else if (r) begin
                m_valid[line_of(ra)] = 1'b1;
                m_tag[line_of(ra)]   = tag_of(ra);
                m_data[line_of(ra)]  = rdt;
            end
            exp_rv   = rd;
            exp_hit  = rd && m_valid[line_of(rda)] && (m_tag[line_of(rda)] == tag_of(rda));
            exp_data = exp_hit ? m_data[line_of(rda)] : '0;
        end
        checkOutput("rd_valid", {127'd0, rd_valid}, {127'd0, exp_rv});
        checkOutput("rd_hit",   {127'd0, rd_hit},   {127'd0, exp_hit});
        checkOutput("rd_data",  rd_data, exp_data);
        checkOutput("hit_cnt",  {96'd0, hit_cnt},  {96'd0, sat32(exp_hits)});
        checkOutput("miss_cnt", {96'd0, miss_cnt}, {96'd0, sat32(exp_misses)});
    endtask

    task automatic idle();
        applyStimulus(0, 0, '0, '0, 0, '0, '0, 0, '0);
    endtask

    task automatic lookup(input logic [ADDR_W-1:0] a);
        applyStimulus(0, 0, '0, '0, 0, '0, '0, 1, a);
    endtask

    task automatic refill(input logic [ADDR_W-1:0] a, input logic [BLOCK_W-1:0] d);
        applyStimulus(0, 0, '0, '0, 1, a, d, 0, '0);
    endtask

    localparam logic [BLOCK_W-1:0] PAT_A5 = {16{8'hA5}};
    localparam logic [BLOCK_W-1:0] PAT_3C = {16{8'h3C}};

    initial begin
        foreach (m_valid[i]) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_data[i]  = '0;
        end
        exp_rv = 0; exp_hit = 0; exp_data = '0; exp_hits = 0; exp_misses = 0;
        aresetn = 1'b0; srst = 1'b0;
        flush_wren = 0; flush_waddr = '0; flush_wdata = '0;
        rfl_wren = 0; rfl_waddr = '0; rfl_wdata = '0;
        rd_en = 0; rd_addr = '0;

        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        checkOutput("reset_rd_valid", {127'd0, rd_valid}, '0);
        checkOutput("reset_rd_hit",   {127'd0, rd_hit},   '0);
        checkOutput("reset_rd_data",  rd_data, '0);
        checkOutput("reset_hit_cnt",  {96'd0, hit_cnt},  '0);
        checkOutput("reset_miss_cnt", {96'd0, miss_cnt}, '0);
        checkOutput("reset_rfl_ready", {127'd0, rfl_ready}, 128'd1);

        $display("[TB] cold lookup, refill and hit at another offset");
        lookup(12'h040);
        idle();
        refill(12'h040, PAT_A5);
        lookup(12'h04C);
        idle();

        $display("[TB] same index, different tag");
        lookup(12'h840);
        idle();

        $display("[TB] flush/refill collision and held refill");
        applyStimulus(0, 1, 12'h040, '1, 1, 12'h040, PAT_3C, 0, '0);
        refill(12'h040, PAT_3C);
        lookup(12'h040);
        idle();

        $display("[TB] full flush sweep including aliased terminal address");
        for (int i = 0; i < 10; i++) begin
            refill(ADDR_W'(i * 3 * BYTES), {4{$urandom}});
        end
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(0, 1, ADDR_W'(i * BYTES), {4{$urandom}}, 0, '0, '0, 0, '0);
        end
        for (int i = 0; i < 10; i++) begin
            lookup(ADDR_W'(i * 3 * BYTES));
        end
        idle();

        $display("[TB] same-cycle read and write to the same index");
        applyStimulus(0, 0, '0, '0, 1, 12'h100, PAT_A5, 1, 12'h100);
        applyStimulus(0, 1, 12'h100, PAT_3C, 0, '0, '0, 1, 12'h100);
        applyStimulus(0, 0, '0, '0, 1, 12'h900, PAT_3C, 1, 12'h100);
        idle();

        $display("[TB] synchronous reset beats a write and drops a lookup");
        refill(12'h200, PAT_A5);
        applyStimulus(1, 0, '0, '0, 1, 12'h210, PAT_3C, 1, 12'h200);
        lookup(12'h200);
        lookup(12'h210);
        idle();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            logic               f, r, rd;
            logic [ADDR_W-1:0]  fa, ra, rda;
            logic [BLOCK_W-1:0] fd, rdt;
            f   = ($urandom_range(0, 9) == 0);
            r   = ($urandom_range(0, 2) == 0);
            rd  = ($urandom_range(0, 1) == 0);
            fa  = ADDR_W'(($urandom_range(0, 1) << 11) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
            ra  = ADDR_W'(($urandom_range(0, 1) << 11) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
            rda = ADDR_W'(($urandom_range(0, 1) << 11) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15));
            fd  = {$urandom, $urandom, $urandom, $urandom};
            rdt = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(($urandom_range(0, 199) == 0), f, fa, fd, r, ra, rdt, rd, rda);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
